// File: rtl/irq_arbiter.sv
// irq_arbiter: mip composition, interrupt qualification, fixed-priority
// selection and req/ack presentation to the trap logic.
module irq_arbiter #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MIP_SW_MASK = 32'h0000_0111
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        irq_msip_i,
  input  logic        irq_mtip_i,
  input  logic        irq_meip_i,
  input  logic        mip_wr_en_i,
  input  logic [31:0] mip_data_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mideleg_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_uie_i,
  input  logic [1:0]  current_mode_i,
  input  logic        irq_ack_i,
  output logic        irq_req_o,
  output logic [31:0] irq_cause_o,
  output logic        irq_deleg_o,
  output logic [31:0] mip_o
);

  localparam logic [1:0]  MODE_M    = 2'b11;
  localparam logic [1:0]  MODE_U    = 2'b00;
  // M-level bits 3/7/11 can never be delegated.
  localparam logic [31:0] M_ONLY    = 32'h0000_0888;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] meip_sync;
  logic [31:0]            sw_bits;
  logic [31:0]            pend, deleg_eff, elig;
  logic                   win_vld;
  logic [4:0]             win_code;
  logic                   load;

  // Synchronizer chain for the asynchronous external interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) meip_sync <= '0;
    else begin
      meip_sync[0] <= irq_meip_i;
      for (int i = 1; i < SYNC_STAGES; i++) meip_sync[i] <= meip_sync[i-1];
    end
  end

  // Software-writable mip bits; other written bits are dropped by the mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            sw_bits <= '0;
    else if (mip_wr_en_i) sw_bits <= mip_data_i & MIP_SW_MASK;
  end

  // Composed mip: hardware M bits OR'ed with software U bits.
  always_comb begin
    mip_o     = sw_bits;
    mip_o[3]  = irq_msip_i;
    mip_o[7]  = irq_mtip_i;
    mip_o[11] = meip_sync[SYNC_STAGES-1];
  end

  // Per-bit eligibility against enables, delegation and privilege mode.
  always_comb begin
    pend      = mip_o & mie_i;
    deleg_eff = mideleg_i & ~M_ONLY;
    for (int b = 0; b < 32; b++) begin
      if (deleg_eff[b])
        elig[b] = pend[b] && (current_mode_i == MODE_U) && mstatus_uie_i;
      else
        elig[b] = pend[b] && ((current_mode_i != MODE_M) || mstatus_mie_i);
    end
  end

  // Fixed priority: MEI > MSI > MTI > UEI > USI > UTI.
  always_comb begin
    win_vld  = 1'b1;
    win_code = 5'd0;
    if      (elig[11]) win_code = 5'd11;
    else if (elig[3])  win_code = 5'd3;
    else if (elig[7])  win_code = 5'd7;
    else if (elig[8])  win_code = 5'd8;
    else if (elig[0])  win_code = 5'd0;
    else if (elig[4])  win_code = 5'd4;
    else               win_vld  = 1'b0;
  end

  // Next-state logic; the latched cause drives the withdraw check in REQ.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (win_vld && en_i) begin
        state_d = REQ;
        load    = 1'b1;
      end
      REQ: begin
        if (irq_ack_i)                     state_d = HOLD;
        else if (!elig[irq_cause_o[4:0]])  state_d = IDLE;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus cause/target capture; outputs frozen outside a load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      irq_cause_o <= '0;
      irq_deleg_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        irq_cause_o <= {1'b1, 26'd0, win_code};
        irq_deleg_o <= deleg_eff[win_code];
      end
    end
  end

  assign irq_req_o = (state_q == REQ);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with an expectation queue (scoreboard).
module tb_irq_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        irq_msip_i, irq_mtip_i, irq_meip_i;
  logic        mip_wr_en_i;
  logic [31:0] mip_data_i, mie_i, mideleg_i;
  logic        mstatus_mie_i, mstatus_uie_i;
  logic [1:0]  current_mode_i;
  logic        irq_ack_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic        irq_deleg_o;
  logic [31:0] mip_o;

  irq_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .irq_msip_i(irq_msip_i), .irq_mtip_i(irq_mtip_i), .irq_meip_i(irq_meip_i),
    .mip_wr_en_i(mip_wr_en_i), .mip_data_i(mip_data_i),
    .mie_i(mie_i), .mideleg_i(mideleg_i),
    .mstatus_mie_i(mstatus_mie_i), .mstatus_uie_i(mstatus_uie_i),
    .current_mode_i(current_mode_i), .irq_ack_i(irq_ack_i),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
    .irq_deleg_o(irq_deleg_o), .mip_o(mip_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        chk_out;
    logic [31:0] cause;
    logic        deleg;
    logic        chk_mip;
    logic [31:0] mip;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(input string tag, input logic req, input logic chk_out,
                      input logic [31:0] cause, input logic deleg,
                      input logic chk_mip, input logic [31:0] mip);
    exp_t e;
    e.req = req; e.chk_out = chk_out; e.cause = cause; e.deleg = deleg;
    e.chk_mip = chk_mip; e.mip = mip;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: got 0 entries required >=1");
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (irq_req_o === e.req) else begin
      errors++;
      $error("FAIL %s req: got %b required %b", t, irq_req_o, e.req);
    end
    if (e.chk_out) begin
      checks += 2;
      assert (irq_cause_o === e.cause) else begin
        errors++;
        $error("FAIL %s cause: got %h required %h", t, irq_cause_o, e.cause);
      end
      assert (irq_deleg_o === e.deleg) else begin
        errors++;
        $error("FAIL %s deleg: got %b required %b", t, irq_deleg_o, e.deleg);
      end
    end
    if (e.chk_mip) begin
      checks++;
      assert (mip_o === e.mip) else begin
        errors++;
        $error("FAIL %s mip: got %h required %h", t, mip_o, e.mip);
      end
    end
  endtask

  // Advance one clock, then check 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    compare();
  endtask

  // Expect a plain req level (no output/mip check) after one clock.
  task automatic req_step(input string tag, input logic req);
    push(tag, req, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
  endtask

  // Expect a request with given cause/target after one clock.
  task automatic out_step(input string tag, input logic [31:0] cause, input logic deleg);
    push(tag, 1'b1, 1'b1, cause, deleg, 1'b0, 32'h0);
    step();
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1;
    irq_msip_i = 0; irq_mtip_i = 0; irq_meip_i = 0;
    mip_wr_en_i = 0; mip_data_i = '0;
    mie_i = 32'h0000_0999; mideleg_i = '0;
    mstatus_mie_i = 1'b1; mstatus_uie_i = 1'b0;
    current_mode_i = 2'b11; irq_ack_i = 1'b0;

    // Reset state
    #12;
    push("reset", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
    compare();
    @(negedge clk_i); rst_i = 1'b0;
    req_step("idle", 1'b0);

    // Timer in M-mode, ack, HOLD, re-request
    irq_mtip_i = 1'b1;
    push("mti_req", 1'b1, 1'b1, 32'h8000_0007, 1'b0, 1'b1, 32'h0000_0080);
    step();
    out_step("mti_hold_req", 32'h8000_0007, 1'b0);
    irq_ack_i = 1'b1;
    req_step("mti_hold", 1'b0);
    irq_ack_i = 1'b0;
    req_step("mti_idle", 1'b0);
    out_step("mti_rereq", 32'h8000_0007, 1'b0);

    // Withdraw: source dropped without ack
    irq_mtip_i = 1'b0;
    req_step("wd_drop", 1'b0);
    req_step("wd_stay", 1'b0);

    // Drop + ack together takes HOLD: re-raise and see a 1-cycle gap
    irq_mtip_i = 1'b1;
    out_step("wd2_req", 32'h8000_0007, 1'b0);
    irq_mtip_i = 1'b0; irq_ack_i = 1'b1;
    req_step("wd2_hold", 1'b0);
    irq_mtip_i = 1'b1; irq_ack_i = 1'b0;
    req_step("wd2_hold_idle", 1'b0);
    out_step("wd2_rereq", 32'h8000_0007, 1'b0);
    irq_mtip_i = 1'b0; irq_ack_i = 1'b1;
    req_step("wd2_ack", 1'b0);
    irq_ack_i = 1'b0;
    req_step("wd2_idle", 1'b0);

    // en_i gating
    en_i = 1'b0; irq_mtip_i = 1'b1;
    for (int i = 0; i < 5; i++) req_step("gate_en0", 1'b0);
    en_i = 1'b1;
    out_step("gate_en1", 32'h8000_0007, 1'b0);
    irq_ack_i = 1'b1; irq_mtip_i = 1'b0;
    req_step("gate_ack", 1'b0);
    irq_ack_i = 1'b0;
    req_step("gate_idle", 1'b0);

    // MIE=0 in M blocks; U-mode ignores MIE for M-target bits
    mstatus_mie_i = 1'b0; irq_mtip_i = 1'b1;
    for (int i = 0; i < 3; i++) req_step("mie0_m", 1'b0);
    current_mode_i = 2'b00;
    out_step("mie0_u", 32'h8000_0007, 1'b0);
    irq_ack_i = 1'b1; irq_mtip_i = 1'b0;
    req_step("mie0_ack", 1'b0);
    irq_ack_i = 1'b0; current_mode_i = 2'b11; mstatus_mie_i = 1'b1;
    req_step("mie0_idle", 1'b0);

    // Priority and freeze: MSI beats MTI, later MEI does not preempt REQ
    irq_msip_i = 1'b1; irq_mtip_i = 1'b1;
    out_step("prio_msi", 32'h8000_0003, 1'b0);
    irq_meip_i = 1'b1;
    for (int i = 0; i < 3; i++) out_step("prio_freeze", 32'h8000_0003, 1'b0);
    irq_ack_i = 1'b1;
    req_step("prio_hold", 1'b0);
    irq_ack_i = 1'b0;
    req_step("prio_idle", 1'b0);
    push("prio_mei", 1'b1, 1'b1, 32'h8000_000B, 1'b0, 1'b1, 32'h0000_0888);
    step();
    irq_msip_i = 1'b0; irq_mtip_i = 1'b0; irq_meip_i = 1'b0; irq_ack_i = 1'b1;
    req_step("prio_ack", 1'b0);
    irq_ack_i = 1'b0;
    req_step("prio_clr1", 1'b0);
    req_step("prio_clr2", 1'b0);

    // Delegation of USI to U-mode
    current_mode_i = 2'b00; mstatus_uie_i = 1'b1; mideleg_i = 32'h0000_0001;
    mip_wr_en_i = 1'b1; mip_data_i = 32'h0000_0001;
    push("deleg_wr", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0001);
    step();
    mip_wr_en_i = 1'b0;
    out_step("deleg_u", 32'h8000_0000, 1'b1);
    current_mode_i = 2'b11;
    req_step("deleg_m_wd", 1'b0);
    req_step("deleg_m", 1'b0);
    mideleg_i = 32'h0000_0889;
    req_step("deleg_m_bits", 1'b0);
    mideleg_i = 32'h0000_0001;
    mip_wr_en_i = 1'b1; mip_data_i = 32'h0;
    req_step("deleg_clr", 1'b0);
    mip_wr_en_i = 1'b0;

    // Non-delegable M bit reported with deleg=0 even if mideleg sets it
    current_mode_i = 2'b00; mideleg_i = 32'h0000_0080; irq_mtip_i = 1'b1;
    out_step("deleg_mti", 32'h8000_0007, 1'b0);
    irq_ack_i = 1'b1; irq_mtip_i = 1'b0;
    req_step("deleg_mti_ack", 1'b0);
    irq_ack_i = 1'b0; mideleg_i = '0; current_mode_i = 2'b11; mstatus_uie_i = 1'b0;
    req_step("deleg_mti_idle", 1'b0);

    // CSR write mask, then async reset during REQ
    irq_mtip_i = 1'b1; mip_wr_en_i = 1'b1; mip_data_i = 32'hFFFF_FFFF;
    push("mask_wr", 1'b1, 1'b1, 32'h8000_0007, 1'b0, 1'b1, 32'h0000_0191);
    step();
    mip_wr_en_i = 1'b0;
    rst_i = 1'b1;
    #1;
    push("rst_req", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    compare();
    @(negedge clk_i); rst_i = 1'b0;
    push("rst_release", 1'b1, 1'b1, 32'h8000_0007, 1'b0, 1'b1, 32'h0000_0080);
    step();

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Interrupt pending/arbitration front-end for the CSR controller.
- Holds the mip register: hardware-driven M-mode bits plus software-writable U-mode bits.
- Qualifies pending interrupts against mie, mideleg, the current privilege mode and the global enables.
- Selects one interrupt by fixed priority and presents it to the trap logic over a req/ack handshake, with cause and delegation target held stable until the request is taken or withdrawn.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on irq_meip_i (minimum 1).
- MIP_SW_MASK, 32'h0000_0111: mip bits writable through the CSR port (USIP[0], UTIP[4], UEIP[8]).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  instruction boundary valid; a new request may only be launched when 1.
- irq_msip_i  in  1  M software interrupt level, on-chip, synchronous.
- irq_mtip_i  in  1  M timer interrupt level, on-chip, synchronous.
- irq_meip_i  in  1  M external interrupt level, asynchronous source.
- mip_wr_en_i  in  1  CSR write strobe for mip.
- mip_data_i  in  32  CSR write data for mip.
- mie_i  in  32  mie register value.
- mideleg_i  in  32  mideleg register value.
- mstatus_mie_i  in  1  mstatus.MIE.
- mstatus_uie_i  in  1  mstatus.UIE.
- current_mode_i  in  2  current privilege mode (2'b11 M, 2'b00 U).
- irq_ack_i  in  1  trap logic has taken the presented interrupt this cycle.
- irq_req_o  out  1  interrupt request to trap logic.
- irq_cause_o  out  32  mcause/ucause value: bit31=1, [30:0]=interrupt code.
- irq_deleg_o  out  1  1: handle in U-mode; 0: handle in M-mode.
- mip_o  out  32  mip read value.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, irq_req_o=0, irq_cause_o=0, irq_deleg_o=0, software mip bits=0, all sync flops=0.
- mip composition:
  - bit3 = irq_msip_i; bit7 = irq_mtip_i; bit11 = output of the SYNC_STAGES-flop synchronizer on irq_meip_i.
  - Software bits update on mip_wr_en_i: sw_bits <= mip_data_i & MIP_SW_MASK. Writes to all other bits are ignored.
  - mip_o = current composed value (combinational from flops). All other bits read 0.
- Qualification: pend = mip & mie_i. For each pending bit b:
  - If mideleg_i[b]=0 (M target): eligible when current_mode_i!=M, or when current_mode_i==M and mstatus_mie_i=1.
  - If mideleg_i[b]=1 (U target): eligible only when current_mode_i==U and mstatus_uie_i=1. Never taken while in M.
  - M bits 3/7/11 are never delegable: their mideleg bit is treated as 0.
- Priority, highest first: MEI(11) > MSI(3) > MTI(7) > UEI(8) > USI(0) > UTI(4).
- FSM:
  - IDLE: if any bit is eligible and en_i=1, register code, bit31 and deleg for the winner; go to REQ. irq_req_o rises the cycle after qualification (1-cycle latency from a synchronous source; SYNC_STAGES+1 from irq_meip_i). If eligible but en_i=0, stay in IDLE.
  - REQ: irq_req_o=1; irq_cause_o and irq_deleg_o frozen even if a higher-priority interrupt appears.
    - irq_ack_i=1: go to HOLD.
    - Latched bit no longer eligible (source dropped, mie cleared, enable cleared, sw bit cleared by CSR write) and no ack: go to IDLE, withdraw irq_req_o next cycle. Re-arbitration happens from IDLE.
    - Ack and loss of eligibility in the same cycle: ack wins, go to HOLD.
  - HOLD: irq_req_o=0 for exactly one cycle, so mstatus/mode updates from the trap are visible; then IDLE.
- Pending bits are level-sensitive. The arbiter never clears mip; the source or software must clear it.
- irq_cause_o and irq_deleg_o keep their last value in IDLE/HOLD. They are valid only while irq_req_o=1.
- Reset asserted mid-REQ: irq_req_o drops immediately (async); the FSM returns to IDLE.

Test Plan:
- Timer, M-mode: mode=M, MIE=1, mie[7]=1, pulse irq_mtip_i high at cycle 10 with en_i=1 -> irq_req_o=1 at cycle 11, irq_cause_o=32'h8000_0007, irq_deleg_o=0. Ack at cycle 13 -> req 0 at cycle 14 (HOLD). Back in IDLE at 15; re-request at 16 if the source is still high.
- Priority and freeze: MTIP and MSIP both high from reset release -> cause 32'h8000_0003. Raise MEIP while in REQ -> cause stays 3 until ack. After HOLD, the next request carries 32'h8000_000B (2-cycle sync delay already elapsed).
- Delegation: mode=U, UIE=1, write mip=32'h1 with mie[0]=1, mideleg[0]=1 -> req with cause 32'h8000_0000, deleg=1. Same setup with mode=M -> no request.
- Withdraw: in REQ for MTI, drop irq_mtip_i with no ack -> irq_req_o=0 next cycle, no HOLD. Drop the source and ack in the same cycle -> HOLD path taken.
- Gating: eligible MTI with en_i=0 for 5 cycles -> no req. en_i=1 -> req next cycle. MIE=0 in M-mode -> never req. mode=U with MIE=0 -> req.
- CSR write mask: write mip=32'hFFFF_FFFF -> mip_o=32'h0000_0111 | hardware bits. Assert rst_i in REQ -> irq_req_o=0 in the same cycle, mip_o software bits=0.
